// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_pkg: shared types and helpers for the memory copy engine.
//   - state_t: controller states (IDLE, RUN, FLUSH, DONE)
//   - *_DEF: default widths for address, data and transfer length
//   - overlap_fwd(): true when [dst, dst+len) starts inside [src, src+len)
//     with dst ahead of src (modulo 2^aw); only used when the build
//     defines MEM_COPY_OVERLAP_DIR_EN.
package mem_copy_pkg;

   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int LEN_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Forward overlap: 0 < (dst - src) mod 2^aw < len.  An ascending copy
   // would then clobber source bytes before they are read.
   function automatic logic overlap_fwd(input logic [31:0] src,
                                        input logic [31:0] dst,
                                        input logic [31:0] len,
                                        input int          aw);
      logic [31:0] mask;
      logic [31:0] diff;
      mask = (32'd1 << aw) - 32'd1;
      diff = (dst - src) & mask;
      return (diff != 32'd0) && (diff < len);
   endfunction

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: byte-memory access bus between the copy engine and
// the on-chip memory.
//   mem_rd_en/mem_rd_addr   read request (engine -> memory)
//   mem_rd_data             read data, valid the cycle after mem_rd_en
//   mem_wr_en/mem_wr_addr/mem_wr_data  write request (engine -> memory)
// Modports: master = engine side, slave = memory side.
interface mem_copy_engine_if
   import mem_copy_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_rd_addr;
   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic                  mem_wr_en;
   logic [ADDR_WIDTH-1:0] mem_wr_addr;
   logic [DATA_WIDTH-1:0] mem_wr_data;

   modport master (
      output mem_rd_en, mem_rd_addr,
      input  mem_rd_data,
      output mem_wr_en, mem_wr_addr, mem_wr_data
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr,
      output mem_rd_data,
      input  mem_wr_en, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/mem_copy_engine_addr_gen.sv
// mem_copy_addr_gen: registered address sequencer (base + offset).
//   clk, rst     clock, synchronous active-high reset
//   load         capture base/count/desc; first address becomes base
//                (ascending) or base+count-1 (descending)
//   step         advance one address in the captured direction
//   desc         direction for the next load (1 = descending)
//   base, count  block start address and length
//   addr         current address (registered, wraps modulo 2^ADDR_WIDTH)
//   last         current address is the final one of the block
module mem_copy_addr_gen
   import mem_copy_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  step,
   input  logic                  desc,
   input  logic [ADDR_WIDTH-1:0] base,
   input  logic [LEN_WIDTH-1:0]  count,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [LEN_WIDTH-1:0]  offset_reg;
   logic [LEN_WIDTH-1:0]  count_reg;
   logic                  desc_reg;
   logic [ADDR_WIDTH-1:0] first_addr;

   // Truncation of count-1 to ADDR_WIDTH gives the modulo wrap for free.
   assign first_addr = desc ? base + ADDR_WIDTH'(count - LEN_WIDTH'(1)) : base;

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg   <= '0;
         offset_reg <= '0;
         count_reg  <= '0;
         desc_reg   <= 1'b0;
      end else if (load) begin
         addr_reg   <= first_addr;
         offset_reg <= '0;
         count_reg  <= count;
         desc_reg   <= desc;
      end else if (step) begin
         addr_reg   <= desc_reg ? addr_reg - ADDR_WIDTH'(1) : addr_reg + ADDR_WIDTH'(1);
         offset_reg <= offset_reg + LEN_WIDTH'(1);
      end
   end

   assign addr = addr_reg;
   assign last = (offset_reg == count_reg - LEN_WIDTH'(1));
endmodule

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies len bytes from src_addr to dst_addr inside one
// byte memory, one byte per cycle, through a 1-cycle-latency read port.
//   clk, rst            clock, synchronous active-high reset
//   start               request pulse, honoured only in IDLE
//   src_addr, dst_addr  block base addresses (captured on accepted start)
//   len                 byte count, clamped to 2^ADDR_WIDTH
//   busy                transfer in progress
//   done                one-cycle completion pulse
//   mem                 memory bus (mem_copy_engine_if.master)
// Optional macro MEM_COPY_OVERLAP_DIR_EN: copy descending when the
// destination overlaps ahead of the source, giving memmove semantics.
module mem_copy_engine
   import mem_copy_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int LEN_WIDTH  = ADDR_WIDTH + 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   mem_copy_engine_if.master     mem
);
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);

   state_t                state_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic                  rd_en_reg;
   logic                  wr_en_reg;
   logic [LEN_WIDTH-1:0]  len_clamped;
   logic                  accept;
   logic                  desc;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  rd_last;
   logic                  wr_last;
   logic [DATA_WIDTH-1:0] wr_data;

   assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
   assign accept      = (state_reg == IDLE) && start;

`ifdef MEM_COPY_OVERLAP_DIR_EN
   assign desc = overlap_fwd(32'(src_addr), 32'(dst_addr), 32'(len_clamped), ADDR_WIDTH);
`else
   assign desc = 1'b0;
`endif

   // Read side steps on every issued read; the write side trails it by
   // exactly one cycle because wr_en_reg is rd_en_reg delayed.
   mem_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) rd_gen (
      .clk(clk), .rst(rst), .load(accept), .step(rd_en_reg), .desc(desc),
      .base(src_addr), .count(len_clamped), .addr(rd_addr), .last(rd_last)
   );

   mem_copy_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) wr_gen (
      .clk(clk), .rst(rst), .load(accept), .step(wr_en_reg), .desc(desc),
      .base(dst_addr), .count(len_clamped), .addr(wr_addr), .last(wr_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         rd_en_reg <= 1'b0;
         wr_en_reg <= 1'b0;
      end else begin
         done_reg  <= 1'b0;
         wr_en_reg <= rd_en_reg;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (len_clamped == '0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                     rd_en_reg <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (rd_last) begin
                  state_reg <= FLUSH;
                  rd_en_reg <= 1'b0;
               end
            end
            FLUSH: begin
               if (wr_last) begin
                  state_reg <= DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Write data is the read data of the previous cycle, passed straight through.
   assign wr_data         = mem.mem_rd_data;
   assign mem.mem_wr_data = wr_data;
   assign mem.mem_rd_en   = rd_en_reg;
   assign mem.mem_rd_addr = rd_addr;
   assign mem.mem_wr_en   = wr_en_reg;
   assign mem.mem_wr_addr = wr_addr;
   assign busy            = busy_reg;
   assign done            = done_reg;
endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int LW = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   mem_copy_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr),
      .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .mem(bus.master)
   );

   // Byte memory: synchronous read, read-before-write on the same edge.
   logic [7:0] mem [0:255];
   logic [7:0] rd_data_q;
   logic       pre_we;
   logic [7:0] pre_addr;
   logic [7:0] pre_data;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.mem_wr_en) mem[bus.mem_wr_addr] <= bus.mem_wr_data;
      if (bus.mem_rd_en) rd_data_q <= mem[bus.mem_rd_addr];
   end
   assign bus.mem_rd_data = rd_data_q;

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   bit check_en = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int ref_mem [256];
   int m_v [256];
   int m_tmp [256];
   bit m_active = 0;
   bit m_desc;
   bit m_was_idle;
   int m_t, m_L, m_src, m_dst, m_diff;

   function automatic int m_ra(input int k);
      return m_desc ? (m_src + m_L - 1 - k) & 255 : (m_src + k) & 255;
   endfunction
   function automatic int m_wa(input int k);
      return m_desc ? (m_dst + m_L - 1 - k) & 255 : (m_dst + k) & 255;
   endfunction
   function automatic int m_last();
      return (m_L == 0) ? 1 : m_L + 2;
   endfunction

   initial forever begin
      @(posedge clk);
      if (pre_we) ref_mem[pre_addr] = int'(pre_data);
      if (m_active && m_t >= 2 && m_t <= m_L + 1) ref_mem[m_wa(m_t - 2)] = m_v[m_t - 2];
      m_was_idle = !m_active;
      if (rst) m_active = 0;
      else if (m_active) begin
         m_t++;
         if (m_t > m_last()) m_active = 0;
      end
      if (!rst && m_was_idle && start) begin
         m_L   = (int'(len) > 256) ? 256 : int'(len);
         m_src = int'(src_addr);
         m_dst = int'(dst_addr);
         m_diff = (m_dst - m_src + 256) % 256;
`ifdef MEM_COPY_OVERLAP_DIR_EN
         m_desc = (m_diff != 0) && (m_diff < m_L);
`else
         m_desc = 0;
`endif
         // Byte k is read while write k-1 lands on the same edge (old value seen).
         m_tmp = ref_mem;
         for (int k = 0; k < m_L; k++) begin
            m_v[k] = m_tmp[m_ra(k)];
            if (k >= 1) m_tmp[m_wa(k - 1)] = m_v[k - 1];
         end
         m_active = 1;
         m_t = 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   bit e_busy, e_done, e_rd, e_wr;
   initial forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (check_en) begin
         e_busy = m_active && m_L > 0 && m_t <= m_L + 1;
         e_done = m_active && m_t == m_last();
         e_rd   = m_active && m_L > 0 && m_t <= m_L;
         e_wr   = m_active && m_t >= 2 && m_t <= m_L + 1;
         chk("busy", int'(busy), int'(e_busy));
         chk("done", int'(done), int'(e_done));
         chk("rd_en", int'(bus.mem_rd_en), int'(e_rd));
         chk("wr_en", int'(bus.mem_wr_en), int'(e_wr));
         if (e_rd) chk("rd_addr", int'(bus.mem_rd_addr), m_ra(m_t - 1));
         if (e_wr) begin
            chk("wr_addr", int'(bus.mem_wr_addr), m_wa(m_t - 2));
            chk("wr_data", int'(bus.mem_wr_data), m_v[m_t - 2]);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int a, input int d);
      pre_we = 1'b1;
      pre_addr = 8'(a);
      pre_data = 8'(d);
      tick();
      pre_we = 1'b0;
   endtask

   task automatic cmp_mem(input string name);
      int diffs;
      diffs = 0;
      for (int i = 0; i < 256; i++)
         if (int'(mem[i]) !== ref_mem[i]) diffs++;
      chk(name, diffs, 0);
   endtask

   task automatic do_copy(input int s, input int d, input int l, input bit noise);
      int base;
      int waited;
      int leff;
      base = done_cnt;
      waited = 0;
      leff = (l > 256) ? 256 : l;
      src_addr = 8'(s);
      dst_addr = 8'(d);
      len = 9'(l);
      start = 1'b1;
      tick();
      start = 1'b0;
      while (1) begin
         if (noise) start = 1'($urandom_range(0, 1));
         tick();
         waited++;
         start = 1'b0;
         if (done_cnt != base || waited >= 600) break;
      end
      $display("copy src=%02h dst=%02h len=%0d latency=%0d", s, d, l, waited);
      chk("done_seen", done_cnt - base, 1);
      chk("latency", waited, (leff == 0) ? 1 : leff + 2);
      cmp_mem("mem_after_copy");
   endtask

   int base_cnt;
   int rs, rd, rl, sel;

   initial begin
      rst = 1'b1;
      start = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len = '0;
      pre_we = 1'b0;
      pre_addr = '0;
      pre_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_rd_en", int'(bus.mem_rd_en), 0);
      chk("rst_wr_en", int'(bus.mem_wr_en), 0);
      chk("rst_rd_addr", int'(bus.mem_rd_addr), 0);
      chk("rst_wr_addr", int'(bus.mem_wr_addr), 0);
      rst = 1'b0;
      check_en = 1;

      for (int i = 0; i < 256; i++) preload(i, int'($urandom_range(0, 255)));

      // basic copy
      preload('h10, 'hA1); preload('h11, 'hB2); preload('h12, 'hC3); preload('h13, 'hD4);
      do_copy('h10, 'h80, 4, 0);
      chk("t1_m80", int'(mem[8'h80]), 'hA1);
      chk("t1_m81", int'(mem[8'h81]), 'hB2);
      chk("t1_m82", int'(mem[8'h82]), 'hC3);
      chk("t1_m83", int'(mem[8'h83]), 'hD4);

      // zero length
      do_copy('h33, 'h44, 0, 0);

      // wrapping addresses, dst = src+3
      preload('hFE, 'h11); preload('hFF, 'h22); preload('h00, 'h33); preload('h01, 'h44);
      do_copy('hFE, 'h01, 4, 0);
      chk("t3_m01", int'(mem[8'h01]), 'h11);
      chk("t3_m02", int'(mem[8'h02]), 'h22);
      chk("t3_m03", int'(mem[8'h03]), 'h33);
`ifdef MEM_COPY_OVERLAP_DIR_EN
      chk("t3_m04", int'(mem[8'h04]), 'h44);
`else
      chk("t3_m04", int'(mem[8'h04]), 'h11);
`endif

      // forward overlap
      preload('h20, 1); preload('h21, 2); preload('h22, 3); preload('h23, 4);
      do_copy('h20, 'h22, 4, 0);
      chk("t4_m22", int'(mem[8'h22]), 1);
      chk("t4_m23", int'(mem[8'h23]), 2);
`ifdef MEM_COPY_OVERLAP_DIR_EN
      chk("t4_m24", int'(mem[8'h24]), 3);
      chk("t4_m25", int'(mem[8'h25]), 4);
`else
      chk("t4_m24", int'(mem[8'h24]), 1);
      chk("t4_m25", int'(mem[8'h25]), 2);
`endif

      // reset in cycle 3 of an 8-byte copy
      for (int i = 0; i < 8; i++) begin
         preload('h40 + i, 'h50 + i);
         preload('h90 + i, 'hEE);
      end
      base_cnt = done_cnt;
      src_addr = 8'h40;
      dst_addr = 8'h90;
      len = 9'd8;
      start = 1'b1;
      tick();                 // cycle 1
      start = 1'b0;
      tick();                 // cycle 2
      tick();                 // cycle 3
      rst = 1'b1;
      tick();                 // cycle 4
      rst = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_en", int'(bus.mem_rd_en), 0);
      chk("abort_wr_en", int'(bus.mem_wr_en), 0);
      chk("abort_rd_addr", int'(bus.mem_rd_addr), 0);
      chk("abort_wr_addr", int'(bus.mem_wr_addr), 0);
      repeat (12) tick();
      $display("copy src=40 dst=90 len=8 aborted by reset");
      chk("abort_no_done", done_cnt - base_cnt, 0);
      chk("abort_m90", int'(mem[8'h90]), 'h50);
      chk("abort_m91", int'(mem[8'h91]), 'h51);
      chk("abort_m92", int'(mem[8'h92]), 'hEE);
      cmp_mem("mem_after_abort");
      do_copy('h40, 'h90, 8, 0);
      chk("retry_m97", int'(mem[8'h97]), 'h57);

      // start held for 12 cycles
      base_cnt = done_cnt;
      src_addr = 8'h60;
      dst_addr = 8'hA0;
      len = 9'd4;
      start = 1'b1;
      repeat (12) tick();
      start = 1'b0;
      repeat (16) tick();
      $display("copy src=60 dst=a0 len=4 start held 12 cycles, transfers=%0d", done_cnt - base_cnt);
      chk("held_start_count", done_cnt - base_cnt, 2);
      cmp_mem("mem_after_held");

      // randomized transfers with start noise while busy
      for (int n = 0; n < 40; n++) begin
         rs = int'($urandom_range(0, 255));
         rd = (n % 3 == 0) ? ((rs + int'($urandom_range(1, 6))) & 255) : int'($urandom_range(0, 255));
         sel = int'($urandom_range(0, 9));
         if (sel == 0) rl = 0;
         else if (sel == 1) rl = int'($urandom_range(257, 511));
         else if (sel == 2) rl = int'($urandom_range(200, 256));
         else rl = int'($urandom_range(1, 16));
         do_copy(rs, rd, rl, 1);
      end

      repeat (4) tick();
      cmp_mem("mem_final");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
